// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode map, FSM states, multiply opcode.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_INC_A  = 4'b0000,
        ALU_INC_B  = 4'b0001,
        ALU_PASS_A = 4'b0010,
        ALU_PASS_B = 4'b0011,
        ALU_DEC_A  = 4'b0100,
        ALU_MUL    = 4'b0101,
        ALU_ADD    = 4'b0110,
        ALU_SUB    = 4'b0111,
        ALU_NOT_A  = 4'b1000,
        ALU_NOT_B  = 4'b1001,
        ALU_AND    = 4'b1010,
        ALU_OR     = 4'b1011,
        ALU_XOR    = 4'b1100,
        ALU_XNOR   = 4'b1101,
        ALU_NAND   = 4'b1110,
        ALU_NOR    = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    localparam alu_op_e OP_MUL = ALU_MUL;

endpackage

// File: rtl/alu_if.sv
// Operand/result handshake bundle between operand fetch and writeback.
// Latency: n/a (wiring only); flag signals exist only with ALU_FLAGS_EN.
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
interface alu_if #(
    parameter int WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   y;
`ifdef ALU_FLAGS_EN
    logic                 flag_z;
    logic                 flag_n;
    logic                 flag_v;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y, flag_z, flag_n, flag_v
    );
    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y, flag_z, flag_n, flag_v
    );
`else
    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y
    );
    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y
    );
`endif
endinterface

// File: rtl/alu_shift_add_mul.sv
// Signed multiplier: magnitude shift-add, one multiplier bit per cycle, sign fixed at the end.
// Latency: WIDTH cycles after start; done/product valid combinationally in the last cycle.
// Backpressure: none; caller must not start while busy and must capture product on done.
module alu_shift_add_mul #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]  acc_q, acc_d;
    logic [PW-1:0]  mcand_q, mcand_d;
    logic [WIDTH:0] mplier_q, mplier_d;
    logic           neg_q, neg_d;
    logic           busy_q, busy_d;
    logic [PW-1:0]  acc_sum;
    logic [WIDTH:0] mag_a, mag_b;
    logic           last;

    // Extending by one bit first lets -2^(WIDTH-1) negate to its true magnitude.
    function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] s;
        s = {v[WIDTH-1], v};
        return v[WIDTH-1] ? -s : s;
    endfunction

    always_comb begin
        mag_a    = magnitude(a);
        mag_b    = magnitude(b);
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
        last     = busy_q && (cnt_q == CW'(WIDTH - 1));
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        busy_d   = busy_q;
        if (start) begin
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = PW'(mag_a);
            mplier_d = mag_b;
            neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (last) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            busy_q   <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign done    = last;
    assign product = neg_q ? -acc_sum : acc_sum;

endmodule

// File: rtl/alu_seq.sv
// Registered signed ALU, full-precision 2*WIDTH result; flags only when ALU_FLAGS_EN is defined.
// Latency: result registered at the accept edge; multiply adds WIDTH edges.
// Backpressure: result and flags held while out_ready=0; in_ready follows out_ready in DONE.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);
    localparam int YW = 2 * WIDTH;
    localparam int AW = WIDTH + 1;

    alu_state_e         state_q, state_d;
    logic [YW-1:0]      y_q, y_d;
    logic [YW-1:0]      alu_res;
    logic [YW-1:0]      mul_prod;
    logic signed [WIDTH:0] ea, eb, arith;
    logic [WIDTH-1:0]   lres;
    alu_op_e            op_in;
    logic               accept, mul_start, mul_busy, mul_done;
    logic               y_load, y_logic;

    assign op_in = alu_op_e'(bus.op);

    always_comb begin
        ea    = {bus.a[WIDTH-1], bus.a};
        eb    = {bus.b[WIDTH-1], bus.b};
        arith = '0;
        lres  = '0;
        case (op_in)
            ALU_INC_A:  arith = ea + AW'(1);
            ALU_INC_B:  arith = eb + AW'(1);
            ALU_PASS_A: arith = ea;
            ALU_PASS_B: arith = eb;
            ALU_DEC_A:  arith = ea - AW'(1);
            ALU_ADD:    arith = ea + eb;
            ALU_SUB:    arith = ea - eb;
            ALU_NOT_A:  lres  = ~bus.a;
            ALU_NOT_B:  lres  = ~bus.b;
            ALU_AND:    lres  = bus.a & bus.b;
            ALU_OR:     lres  = bus.a | bus.b;
            ALU_XOR:    lres  = bus.a ^ bus.b;
            ALU_XNOR:   lres  = ~(bus.a ^ bus.b);
            ALU_NAND:   lres  = ~(bus.a & bus.b);
            ALU_NOR:    lres  = ~(bus.a | bus.b);
            default:    arith = '0;
        endcase
        alu_res = bus.op[3] ? {{WIDTH{lres[WIDTH-1]}}, lres}
                            : {{(WIDTH-1){arith[WIDTH]}}, arith};
    end

    always_comb begin
        state_d       = state_q;
        y_d           = y_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        accept        = 1'b0;
        mul_start     = 1'b0;
        y_load        = 1'b0;
        y_logic       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                accept       = bus.in_valid;
            end
            ST_MUL: begin
                if (mul_done) begin
                    y_d     = mul_prod;
                    y_load  = 1'b1;
                    state_d = ST_DONE;
                end else if (!mul_busy) begin
                    // Multiplier idle without a result: nothing to wait for.
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                bus.in_ready  = bus.out_ready;
                if (bus.out_ready) begin
                    accept = bus.in_valid;
                    if (!bus.in_valid) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            if (op_in == OP_MUL) begin
                mul_start = 1'b1;
                state_d   = ST_MUL;
            end else begin
                y_d     = alu_res;
                y_load  = 1'b1;
                y_logic = bus.op[3];
                state_d = ST_DONE;
            end
        end
    end

    alu_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (bus.a),
        .b       (bus.b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
        end
    end

    assign bus.y = y_q;

`ifdef ALU_FLAGS_EN
    logic flag_z_q, flag_z_d;
    logic flag_n_q, flag_n_d;
    logic flag_v_q, flag_v_d;
    logic fits;

    // Fits in WIDTH-bit signed when every bit above the WIDTH-bit sign matches it.
    always_comb begin
        fits     = (&y_d[YW-1:WIDTH-1]) | ~(|y_d[YW-1:WIDTH-1]);
        flag_z_d = flag_z_q;
        flag_n_d = flag_n_q;
        flag_v_d = flag_v_q;
        if (y_load) begin
            flag_z_d = (y_d == '0);
            flag_n_d = y_d[YW-1];
            flag_v_d = !y_logic && !fits;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
            flag_v_q <= 1'b0;
        end else begin
            flag_z_q <= flag_z_d;
            flag_n_q <= flag_n_d;
            flag_v_q <= flag_v_d;
        end
    end

    assign bus.flag_z = flag_z_q;
    assign bus.flag_n = flag_n_q;
    assign bus.flag_v = flag_v_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=4; flag checks compile in with ALU_FLAGS_EN.
// Inputs change and outputs are sampled on the falling edge.
module tb_alu_seq;
    import alu_pkg::*;

    typedef struct packed {
        logic [7:0] y;
        logic       z;
        logic       n;
        logic       v;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t exp_q[$];

    alu_if #(.WIDTH(4)) bus ();

    alu_seq #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t model(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        int sa, sb, r;
        logic [3:0] l;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = 0;
        l  = '0;
        if (!op[3]) begin
            case (op[2:0])
                3'd0: r = sa + 1;
                3'd1: r = sb + 1;
                3'd2: r = sa;
                3'd3: r = sb;
                3'd4: r = sa - 1;
                3'd5: r = sa * sb;
                3'd6: r = sa + sb;
                default: r = sa - sb;
            endcase
        end else begin
            case (op[2:0])
                3'd0: l = ~a;
                3'd1: l = ~b;
                3'd2: l = a & b;
                3'd3: l = a | b;
                3'd4: l = a ^ b;
                3'd5: l = ~(a ^ b);
                3'd6: l = ~(a & b);
                default: l = ~(a | b);
            endcase
            r = int'($signed(l));
        end
        e.y = r[7:0];
        e.z = (r == 0);
        e.n = (r < 0);
        e.v = !op[3] && (r > 7 || r < -8);
        return e;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.op = 4'h0;
        bus.a = 4'h0;
        bus.b = 4'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        total++; if (bus.y !== 8'h00) begin bad++; $display("FAIL reset_y: got %h want 00", bus.y); end
`ifdef ALU_FLAGS_EN
        total++; if ({bus.flag_z, bus.flag_n, bus.flag_v} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {bus.flag_z, bus.flag_n, bus.flag_v}); end
`endif
    endtask

    task automatic test_add_overflow();
        exp_t e;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.op = ALU_ADD; bus.a = 4'd7; bus.b = 4'd1;
        exp_q.push_back(model(ALU_ADD, 4'd7, 4'd1));
        @(negedge clk);
        bus.in_valid = 1'b0; bus.a = 4'hF; bus.b = 4'hF;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL add_latency: out_valid got %b want 1", bus.out_valid); end
        e = exp_q.pop_front();
        total++; if (bus.y !== e.y) begin bad++; $display("FAIL add_y: got %h want %h", bus.y, e.y); end
`ifdef ALU_FLAGS_EN
        total++; if ({bus.flag_z, bus.flag_n, bus.flag_v} !== {e.z, e.n, e.v}) begin bad++; $display("FAIL add_flags: got %b want %b", {bus.flag_z, bus.flag_n, bus.flag_v}, {e.z, e.n, e.v}); end
`endif
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL add_release: out_valid got %b want 0", bus.out_valid); end
    endtask

    task automatic test_mul(input logic [3:0] a, input logic [3:0] b, input string name);
        exp_t e;
        int   edges;
        bit   rdy_bad;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.op = ALU_MUL; bus.a = a; bus.b = b;
        exp_q.push_back(model(ALU_MUL, a, b));
        edges = -1;
        rdy_bad = 1'b0;
        do begin
            @(negedge clk);
            edges++;
            if (bus.in_ready !== 1'b0) rdy_bad = 1'b1;
            bus.in_valid = 1'b0;
            bus.op = ALU_ADD;
            bus.a = 4'($urandom);
            bus.b = 4'($urandom);
        end while (bus.out_valid !== 1'b1 && edges < 20);
        total++; if (edges != 4) begin bad++; $display("FAIL %s_latency: got %0d edges want 4", name, edges); end
        total++; if (rdy_bad) begin bad++; $display("FAIL %s_in_ready: got 1 during multiply want 0", name); end
        e = exp_q.pop_front();
        total++; if (bus.y !== e.y) begin bad++; $display("FAIL %s_y: got %h want %h", name, bus.y, e.y); end
`ifdef ALU_FLAGS_EN
        total++; if ({bus.flag_z, bus.flag_n, bus.flag_v} !== {e.z, e.n, e.v}) begin bad++; $display("FAIL %s_flags: got %b want %b", name, {bus.flag_z, bus.flag_n, bus.flag_v}, {e.z, e.n, e.v}); end
`endif
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_logic();
        exp_t e;
        logic [3:0] ops [2];
        logic [3:0] as  [2];
        logic [3:0] bs  [2];
        ops[0] = ALU_NAND;  as[0] = 4'hC; bs[0] = 4'hA;
        ops[1] = ALU_NOT_A; as[1] = 4'h0; bs[1] = 4'h5;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            bus.in_valid = 1'b1; bus.op = ops[i]; bus.a = as[i]; bus.b = bs[i];
            exp_q.push_back(model(ops[i], as[i], bs[i]));
            @(negedge clk);
            bus.in_valid = 1'b0;
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL logic%0d_valid: got %b want 1", i, bus.out_valid); end
            e = exp_q.pop_front();
            total++; if (bus.y !== e.y) begin bad++; $display("FAIL logic%0d_y: got %h want %h", i, bus.y, e.y); end
`ifdef ALU_FLAGS_EN
            total++; if ({bus.flag_z, bus.flag_n, bus.flag_v} !== {e.z, e.n, e.v}) begin bad++; $display("FAIL logic%0d_flags: got %b want %b", i, {bus.flag_z, bus.flag_n, bus.flag_v}, {e.z, e.n, e.v}); end
`endif
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        logic [7:0] y0;
        bit hold_bad;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.op = ALU_ADD; bus.a = 4'd2; bus.b = 4'd3;
        exp_q.push_back(model(ALU_ADD, 4'd2, 4'd3));
        @(negedge clk);
        y0 = bus.y;
        bus.op = ALU_XOR; bus.a = 4'd5; bus.b = 4'd3;
        hold_bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.y !== y0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) hold_bad = 1'b1;
        end
        total++; if (hold_bad) begin bad++; $display("FAIL bp_hold: y/in_ready/out_valid changed while stalled, y got %h want %h", bus.y, y0); end
        e = exp_q.pop_front();
        total++; if (bus.y !== e.y) begin bad++; $display("FAIL bp_held_y: got %h want %h", bus.y, e.y); end
        bus.out_ready = 1'b1;
        exp_q.push_back(model(ALU_XOR, 4'd5, 4'd3));
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_next_valid: got %b want 1", bus.out_valid); end
        e = exp_q.pop_front();
        total++; if (bus.y !== e.y) begin bad++; $display("FAIL bp_next_y: got %h want %h", bus.y, e.y); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_release: out_valid got %b want 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [3:0] ops [3];
        logic [3:0] as  [3];
        logic [3:0] bs  [3];
        ops[0] = ALU_INC_A; as[0] = 4'd3; bs[0] = 4'd0;
        ops[1] = ALU_SUB;   as[1] = 4'd2; bs[1] = 4'd5;
        ops[2] = ALU_NOT_B; as[2] = 4'd1; bs[2] = 4'd6;
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.op = ops[i]; bus.a = as[i]; bus.b = bs[i];
            exp_q.push_back(model(ops[i], as[i], bs[i]));
            @(negedge clk);
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL b2b%0d_valid: got %b want 1", i, bus.out_valid); end
            e = exp_q.pop_front();
            total++; if (bus.y !== e.y) begin bad++; $display("FAIL b2b%0d_y: got %h want %h", i, bus.y, e.y); end
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: out_valid got %b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid_mul();
        exp_t e;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.op = ALU_MUL; bus.a = 4'd3; bus.b = 4'd3;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstmul_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.y !== 8'h00) begin bad++; $display("FAIL rstmul_y: got %h want 00", bus.y); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rstmul_in_ready: got %b want 1", bus.in_ready); end
        bus.in_valid = 1'b1; bus.op = ALU_ADD; bus.a = 4'd2; bus.b = 4'd2;
        exp_q.push_back(model(ALU_ADD, 4'd2, 4'd2));
        @(negedge clk);
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rstmul_add_valid: got %b want 1", bus.out_valid); end
        e = exp_q.pop_front();
        total++; if (bus.y !== e.y) begin bad++; $display("FAIL rstmul_add_y: got %h want %h", bus.y, e.y); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstmul_stale: out_valid got %b want 0", bus.out_valid); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_add_overflow();
        test_mul(4'h8, 4'h8, "mul_min");
        test_mul(4'hD, 4'h5, "mul_neg");
        test_logic();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_empty: got %0d entries want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
